// File: rtl/mdu_seq.sv
// Multi-cycle MIPS multiply/divide sequencer: restoring 32-step divider and counted multiply.
// Optional macro MDU_DIV_EARLY_EXIT_EN finishes |a| < |b| divides immediately.
module mdu_seq #(
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  logic        is_div_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        ready_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_e;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(31);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      rq_q, rq_d;
  logic [31:0]      dvs_q, dvs_d;
  logic             sgn_q, sgn_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        early_exit;
  logic [32:0] rem_sh, rem_sub;
  logic [63:0] step_rq;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] mul_a, mul_b;
  logic [63:0] prod;

  assign a_neg = signed_i & a_i[31];
  assign b_neg = signed_i & b_i[31];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

`ifdef MDU_DIV_EARLY_EXIT_EN
  assign early_exit = (a_mag < b_mag);
`else
  assign early_exit = 1'b0;
`endif

  // The shifted partial remainder needs 33 bits: it can exceed 32 bits for large divisors.
  assign rem_sh  = rq_q[63:31];
  assign rem_sub = rem_sh - {1'b0, dvs_q};
  assign step_rq = (rem_sh >= {1'b0, dvs_q}) ? {rem_sub[31:0], rq_q[30:0], 1'b1}
                                             : {rem_sh[31:0],  rq_q[30:0], 1'b0};
  assign quo_fix = quo_neg_q ? -step_rq[31:0]  : step_rq[31:0];
  assign rem_fix = rem_neg_q ? -step_rq[63:32] : step_rq[63:32];

  // Sign-extending to 64 bits makes one truncated multiply serve both MULT and MULTU.
  assign mul_a = rq_q[31:0];
  assign mul_b = dvs_q;
  assign prod  = {{32{sgn_q & mul_a[31]}}, mul_a} * {{32{sgn_q & mul_b[31]}}, mul_b};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rq_d      = rq_q;
    dvs_d     = dvs_q;
    sgn_d     = sgn_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          cnt_d = '0;
          if (is_div_i) begin
            if (b_i == 32'd0) begin
              hi_d    = a_i;
              lo_d    = '1;
              state_d = DONE;
            end else if (early_exit) begin
              hi_d    = a_i;
              lo_d    = '0;
              state_d = DONE;
            end else begin
              rq_d      = {32'd0, a_mag};
              dvs_d     = b_mag;
              quo_neg_d = a_neg ^ b_neg;
              rem_neg_d = a_neg;
              state_d   = DIV;
            end
          end else begin
            rq_d    = {32'd0, a_i};
            dvs_d   = b_i;
            sgn_d   = signed_i;
            state_d = MUL;
          end
        end
      end
      DIV: begin
        rq_d  = step_rq;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == DIV_LAST) begin
          hi_d    = rem_fix;
          lo_d    = quo_fix;
          state_d = DONE;
        end
      end
      MUL: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == MUL_LAST) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // An abandoned op must never reach the result registers.
    if (flush_i) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rq_q      <= '0;
      dvs_q     <= '0;
      sgn_q     <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rq_q      <= rq_d;
      dvs_q     <= dvs_d;
      sgn_q     <= sgn_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign ready_o = (state_q == DONE) & ~flush_i;
  assign stall_o = valid_i & ~ready_o & ~flush_i;
  assign busy_o  = (state_q != IDLE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vector table, flush/reset sequences,
// and random ops checked against an arithmetic reference model.
module tb_mdu_seq;

  localparam int MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_i, is_div_i, signed_i, flush_i;
  logic [31:0] a_i, b_i;
  logic        stall_o, busy_o, ready_o;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_hi, last_lo;

  always #5 clk = ~clk;

  mdu_seq #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(6)) dut (
    .clk(clk), .resetn(resetn), .valid_i(valid_i), .is_div_i(is_div_i),
    .signed_i(signed_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .stall_o(stall_o), .busy_o(busy_o), .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  typedef struct {
    logic        is_div;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on the architectural definition of each op.
  task automatic refModel(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output int lat);
    int          sa, sb;
    longint      la, lb, lp;
    logic [63:0] up;
    logic [31:0] am, bm;
    sa = a;
    sb = b;
    am = (s && sa < 0) ? 32'(-sa) : a;
    bm = (s && sb < 0) ? 32'(-sb) : b;
    if (d) begin
      lat = 33;
      if (b == 0) begin
        hi  = a;
        lo  = 32'hFFFFFFFF;
        lat = 1;
      end else if (s) begin
        hi = 32'(sa % sb);
        lo = 32'(sa / sb);
      end else begin
        hi = a % b;
        lo = a / b;
      end
`ifdef MDU_DIV_EARLY_EXIT_EN
      if (b != 0 && am < bm) lat = 1;
`endif
    end else begin
      lat = MUL_CYCLES + 1;
      if (s) begin
        la = longint'(sa);
        lb = longint'(sb);
        lp = la * lb;
        up = 64'(lp);
      end else begin
        up = {32'd0, a} * {32'd0, b};
      end
      hi = up[63:32];
      lo = up[31:0];
    end
  endtask

  // Drives one op starting in the current cycle (cycle 0) and waits a bounded time for ready_o.
  task automatic applyStimulus(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] eh, input logic [31:0] el, input int lat,
                               input string tag);
    bit seen;
    valid_i  = 1'b1;
    is_div_i = d;
    signed_i = s;
    a_i      = a;
    b_i      = b;
    seen     = 1'b0;
    for (int cyc = 0; cyc <= lat + 3 && !seen; cyc++) begin
      if (cyc > 0) begin
        nextCycle();
        a_i = $urandom;
        b_i = $urandom;
      end
      #2;
      if (ready_o) begin
        seen = 1'b1;
        checkOutput({tag, " latency"}, 64'(cyc), 64'(lat));
        checkOutput({tag, " hi"}, 64'(hi_o), 64'(eh));
        checkOutput({tag, " lo"}, 64'(lo_o), 64'(el));
        checkOutput({tag, " stall at ready"}, 64'(stall_o), 64'd0);
      end else if (cyc == 0) begin
        checkOutput({tag, " stall c0"}, 64'(stall_o), 64'd1);
        checkOutput({tag, " busy c0"}, 64'(busy_o), 64'd0);
      end else if (cyc == 1) begin
        checkOutput({tag, " busy c1"}, 64'(busy_o), 64'd1);
      end
    end
    if (!seen) checkOutput({tag, " ready timeout"}, 64'd0, 64'd1);
    last_hi = eh;
    last_lo = el;
    nextCycle();
    valid_i = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] ra, rb, eh, el;
    logic        rd, rs;
    int          lat;

    vecs[0] = '{1'b1, 1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         33};
    vecs[1] = '{1'b1, 1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   33};
    vecs[2] = '{1'b1, 1'b1, 32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   33};
    vecs[3] = '{1'b0, 1'b1, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFE,   MUL_CYCLES + 1};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFFFFFF,   32'd2,          32'd1,          32'hFFFFFFFE,   MUL_CYCLES + 1};
    vecs[5] = '{1'b1, 1'b0, 32'd5,          32'd0,          32'd5,          32'hFFFFFFFF,   1};
    vecs[6] = '{1'b1, 1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   32'hFFFFFFFF,   1};
`ifdef MDU_DIV_EARLY_EXIT_EN
    vecs[7] = '{1'b1, 1'b0, 32'd3,          32'd9,          32'd3,          32'd0,          1};
`else
    vecs[7] = '{1'b1, 1'b0, 32'd3,          32'd9,          32'd3,          32'd0,          33};
`endif

    resetn   = 1'b0;
    valid_i  = 1'b0;
    is_div_i = 1'b0;
    signed_i = 1'b0;
    flush_i  = 1'b0;
    a_i      = '0;
    b_i      = '0;
    repeat (2) nextCycle();
    checkOutput("reset busy",  64'(busy_o),  64'd0);
    checkOutput("reset ready", 64'(ready_o), 64'd0);
    checkOutput("reset stall", 64'(stall_o), 64'd0);
    checkOutput("reset hi",    64'(hi_o),    64'd0);
    checkOutput("reset lo",    64'(lo_o),    64'd0);
    resetn = 1'b1;
    nextCycle();

    for (int i = 0; i < 8; i++)
      applyStimulus(vecs[i].is_div, vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat, $sformatf("vec%0d", i));

    // Flush in cycle 10 of a divide: no ready, results untouched, new MULTU next cycle.
    valid_i  = 1'b1;
    is_div_i = 1'b1;
    signed_i = 1'b0;
    a_i      = 32'd100;
    b_i      = 32'd7;
    for (int c = 1; c <= 10; c++) nextCycle();
    flush_i = 1'b1;
    #1;
    checkOutput("flush ready", 64'(ready_o), 64'd0);
    checkOutput("flush stall", 64'(stall_o), 64'd0);
    nextCycle();
    flush_i = 1'b0;
    checkOutput("flush busy", 64'(busy_o), 64'd0);
    checkOutput("flush hi kept", 64'(hi_o), 64'(last_hi));
    checkOutput("flush lo kept", 64'(lo_o), 64'(last_lo));
    applyStimulus(1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, MUL_CYCLES + 1, "post-flush mul");

    // Reset in cycle 15 of a divide.
    valid_i  = 1'b1;
    is_div_i = 1'b1;
    signed_i = 1'b0;
    a_i      = 32'd1000;
    b_i      = 32'd3;
    for (int c = 1; c <= 15; c++) nextCycle();
    resetn  = 1'b0;
    valid_i = 1'b0;
    #1;
    checkOutput("midrst busy",  64'(busy_o),  64'd0);
    checkOutput("midrst stall", 64'(stall_o), 64'd0);
    checkOutput("midrst hi",    64'(hi_o),    64'd0);
    checkOutput("midrst lo",    64'(lo_o),    64'd0);
    nextCycle();
    resetn = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 33, "post-reset div");

    for (int i = 0; i < 30; i++) begin
      rd = 1'($urandom);
      rs = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       ra = $urandom_range(0, 50);
        1:       ra = 32'hFFFFFFFF - $urandom_range(0, 50);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = 32'hFFFFFFFF - $urandom_range(0, 20);
        default: rb = $urandom;
      endcase
      if (rd && rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      refModel(rd, rs, ra, rb, eh, el, lat);
      applyStimulus(rd, rs, ra, rb, eh, el, lat, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
